answer_selector_multi: RTL and testbench

Parametrised successor to the 3-bit answer-select code generator. Debounces the up/down/center buttons, steps a selection index over `NUM_ANSWERS` choices with optional wrap-around, and locks the choice on center press until cleared. Drives a one-hot LED vector directly, so it sits between the board buttons and the answer LEDs or scoring logic.

---
 rtl/answer_selector_multi.sv | 174 +++++++++++++++++
 tb/tb_answer_selector_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/answer_selector_multi.sv
`timescale 1ns/1ps
// answer_selector_multi: debounced up/down/center selection over NUM_ANSWERS
// choices with optional wrap-around, lock on center, unlock on clear.
// Optional auto-repeat on a held up/down button: ANSWER_SELECTOR_AUTOREPEAT_EN.
module answer_selector_multi #(
    parameter int unsigned NUM_ANSWERS     = 8,
    parameter int unsigned CODE_W          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned WRAP            = 1,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 20000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_button,
    input  logic                   down_button,
    input  logic                   center_button,
    input  logic                   clear,
    output logic [CODE_W-1:0]      out_answer_select_code,
    output logic                   out_locked,
    output logic                   out_lock_pulse,
    output logic [NUM_ANSWERS-1:0] out_LED
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(NUM_ANSWERS - 1);

    if (NUM_ANSWERS < 2 || NUM_ANSWERS > 256 || (2 ** CODE_W) < NUM_ANSWERS ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("answer_selector_multi: invalid parameter set");
    end

    typedef enum logic {
        S_SELECT,
        S_LOCKED
    } state_e;

    // Button index: 0 = up, 1 = down, 2 = center.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [DB_W-1:0] cnt_q [3];

    state_e          state_q;
    logic [CODE_W-1:0] code_q, code_inc_d, code_dec_d;
    logic            lock_pulse_q;
    logic            up_ev, down_ev;

    assign btn_raw = {center_button, down_button, up_button};

    // Synchronise, debounce and edge-detect each button into a registered press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    deb_q[i] <= ~deb_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef ANSWER_SELECTOR_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic             rpt_active_q, rpt_first_q, rpt_up_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             one_held, rpt_fire;

    assign one_held = deb_q[0] ^ deb_q[1];
    assign rpt_fire = rpt_active_q && one_held && (deb_q[0] == rpt_up_q) &&
                      (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD)));

    // Repeat timer: counts from the press pulse; first interval REPEAT_DELAY, then REPEAT_PERIOD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_active_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_up_q     <= 1'b0;
            rpt_cnt_q    <= '0;
        end else if (state_q != S_SELECT || clear || !one_held ||
                     (rpt_active_q && (deb_q[0] != rpt_up_q))) begin
            rpt_active_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
        end else if ((press_q[0] && deb_q[0]) || (press_q[1] && deb_q[1])) begin
            rpt_active_q <= 1'b1;
            rpt_first_q  <= 1'b1;
            rpt_up_q     <= deb_q[0];
            rpt_cnt_q    <= RPT_W'(1);
        end else if (rpt_active_q) begin
            if (rpt_fire) begin
                rpt_first_q <= 1'b0;
                rpt_cnt_q   <= RPT_W'(1);
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
        end
    end

    assign up_ev   = press_q[0] | (rpt_fire &  rpt_up_q);
    assign down_ev = press_q[1] | (rpt_fire & ~rpt_up_q);
`else
    assign up_ev   = press_q[0];
    assign down_ev = press_q[1];
`endif

    // Neighbouring codes with wrap or saturation at the ends.
    always_comb begin
        code_inc_d = code_q + 1'b1;
        code_dec_d = code_q - 1'b1;
        if (code_q == CODE_LAST) code_inc_d = (WRAP != 0) ? '0 : code_q;
        if (code_q == '0)        code_dec_d = (WRAP != 0) ? CODE_LAST : code_q;
    end

    // Selection FSM: clear has top priority, center beats up/down, up+down cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_SELECT;
            code_q       <= '0;
            lock_pulse_q <= 1'b0;
        end else begin
            lock_pulse_q <= 1'b0;
            case (state_q)
                S_SELECT: begin
                    if (clear) begin
                        code_q <= '0;
                    end else if (press_q[2]) begin
                        state_q      <= S_LOCKED;
                        lock_pulse_q <= 1'b1;
                    end else if (up_ev && !down_ev) begin
                        code_q <= code_inc_d;
                    end else if (down_ev && !up_ev) begin
                        code_q <= code_dec_d;
                    end
                end
                S_LOCKED: begin
                    if (clear) begin
                        state_q <= S_SELECT;
                        code_q  <= '0;
                    end
                end
                default: state_q <= S_SELECT;
            endcase
        end
    end

    // One-hot LED vector decoded from the registered code.
    always_comb begin
        out_LED = '0;
        for (int unsigned i = 0; i < NUM_ANSWERS; i++) out_LED[i] = (code_q == CODE_W'(i));
    end

    assign out_answer_select_code = code_q;
    assign out_locked             = (state_q == S_LOCKED);
    assign out_lock_pulse         = lock_pulse_q;

endmodule

// File: tb/tb_answer_selector_multi.sv
`timescale 1ns/1ps
// Bench for answer_selector_multi: one wrapping and one saturating instance
// share stimulus; expectations come from an event-level model of the selector.
module tb_answer_selector_multi;

    localparam int unsigned NA = 5;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst, up, dn, ct, clr;
    logic [2:0]  code_w, code_s;
    logic        locked_w, locked_s, pulse_w, pulse_s;
    logic [NA-1:0] led_w, led_s;
    logic [17:0] obs;

    int n_checks = 0;
    int n_pass   = 0;
    int model_w, model_s;
    bit model_locked;
    int pulses_w = 0, pulses_s = 0;

    always #5 clk = ~clk;

    answer_selector_multi #(
        .NUM_ANSWERS(NA), .CODE_W(3), .DEBOUNCE_CYCLES(DB), .WRAP(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_w (
        .clk(clk), .rst(rst), .up_button(up), .down_button(dn), .center_button(ct),
        .clear(clr), .out_answer_select_code(code_w), .out_locked(locked_w),
        .out_lock_pulse(pulse_w), .out_LED(led_w)
    );

    answer_selector_multi #(
        .NUM_ANSWERS(NA), .CODE_W(3), .DEBOUNCE_CYCLES(DB), .WRAP(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_s (
        .clk(clk), .rst(rst), .up_button(up), .down_button(dn), .center_button(ct),
        .clear(clr), .out_answer_select_code(code_s), .out_locked(locked_s),
        .out_lock_pulse(pulse_s), .out_LED(led_s)
    );

    assign obs = {code_w, code_s, locked_w, locked_s, led_w, led_s};

    always @(negedge clk) begin
        if (pulse_w) pulses_w++;
        if (pulse_s) pulses_s++;
    end

    // ---------------- reference model ----------------
    function automatic int step(input int c, input int dir, input bit wrap);
        if (dir > 0) return (c == NA - 1) ? (wrap ? 0 : c) : c + 1;
        else         return (c == 0) ? (wrap ? NA - 1 : 0) : c - 1;
    endfunction

    function automatic logic [17:0] exp_vec();
        return {3'(model_w), 3'(model_s), model_locked, model_locked,
                5'(1 << model_w), 5'(1 << model_s)};
    endfunction

    task automatic model_press(input logic [2:0] mask);
        if (model_locked) return;
        if (mask[2]) model_locked = 1'b1;
        else if (mask[0] && !mask[1]) begin
            model_w = step(model_w, 1, 1'b1);
            model_s = step(model_s, 1, 1'b0);
        end else if (mask[1] && !mask[0]) begin
            model_w = step(model_w, -1, 1'b1);
            model_s = step(model_s, -1, 1'b0);
        end
    endtask

    task automatic model_clear();
        model_w = 0; model_s = 0; model_locked = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bits: 0 = up, 1 = down, 2 = center
    task automatic press(input logic [2:0] mask, input int h);
        {ct, dn, up} = mask;
        cycles(h);
        {ct, dn, up} = 3'b000;
        cycles(12);
        model_press(mask);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        cycles(1);
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset_state();
        rst = 1'b1; up = 0; dn = 0; ct = 0; clr = 0;
        model_clear();
        cycles(3);
        n_checks++;
        if (obs !== exp_vec() || pulse_w !== 1'b0 || pulse_s !== 1'b0)
            $display("FAIL reset_state: got %h pulses %b%b expected %h pulses 00", obs, pulse_w, pulse_s, exp_vec());
        else n_pass++;
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_debounce();
        int unsigned p;
        // short press: 3 cycles is below the debounce threshold
        up = 1'b1; cycles(3); up = 1'b0; cycles(12);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL debounce_glitch: got %h expected %h", obs, exp_vec());
        else n_pass++;
        // 10-cycle press: code moves exactly at edge N+8
        p = pulses_w;
        up = 1'b1;
        cycles(7);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL debounce_edge7: got %h expected %h", obs, exp_vec());
        else n_pass++;
        cycles(1);
        model_press(3'b001);
        n_checks++;
        if (obs !== exp_vec() || led_w !== 5'b00010)
            $display("FAIL debounce_edge8: got %h expected %h", obs, exp_vec());
        else n_pass++;
        cycles(2); up = 1'b0; cycles(12);
        n_checks++;
        if (obs !== exp_vec() || pulses_w != p)
            $display("FAIL debounce_release: got %h pulses %0d expected %h pulses %0d", obs, pulses_w, exp_vec(), p);
        else n_pass++;
    endtask

    task automatic test_wrap_saturate();
        logic [2:0] seq [7] = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        pulse_clear();
        foreach (seq[i]) begin
            press(seq[i], 6);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL wrap_sat_%0d: got %h expected %h", i, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        int unsigned pw, ps;
        pulse_clear();
        press(3'b001, 5); press(3'b001, 5); press(3'b001, 5);
        pw = pulses_w; ps = pulses_s;
        press(3'b100, 6);
        n_checks++;
        if (obs !== exp_vec() || pulses_w != pw + 1 || pulses_s != ps + 1)
            $display("FAIL lock_enter: got %h pulses %0d/%0d expected %h pulses %0d/%0d",
                     obs, pulses_w - pw, pulses_s - ps, exp_vec(), 1, 1);
        else n_pass++;
        press(3'b001, 6); press(3'b010, 6); press(3'b100, 6);
        n_checks++;
        if (obs !== exp_vec() || pulses_w != pw + 1)
            $display("FAIL lock_ignore: got %h pulses %0d expected %h pulses %0d", obs, pulses_w - pw, exp_vec(), 1);
        else n_pass++;
        pulse_clear();
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL lock_clear: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int unsigned pw;
        press(3'b001, 5); press(3'b001, 5);
        press(3'b011, 6);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL updown_same: got %h expected %h", obs, exp_vec());
        else n_pass++;
        // center press pulse lands on the same edge that samples clear
        pw = pulses_w;
        ct = 1'b1;
        cycles(7);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        model_clear();
        cycles(2); ct = 1'b0; cycles(12);
        n_checks++;
        if (obs !== exp_vec() || pulses_w != pw)
            $display("FAIL center_clear: got %h pulses %0d expected %h pulses %0d", obs, pulses_w - pw, exp_vec(), 0);
        else n_pass++;
    endtask

    task automatic test_autorepeat();
        int n_steps, exp_ch_w, exp_ch_s, ch_w, ch_s, first_w, nw, ns;
        logic [2:0] prev_w, prev_s;
`ifdef ANSWER_SELECTOR_AUTOREPEAT_EN
        n_steps = 6;
`else
        n_steps = 1;
`endif
        pulse_clear();
        exp_ch_w = 0; exp_ch_s = 0;
        for (int k = 0; k < n_steps; k++) begin
            nw = step(model_w, 1, 1'b1);
            ns = step(model_s, 1, 1'b0);
            if (nw != model_w) exp_ch_w++;
            if (ns != model_s) exp_ch_s++;
            model_w = nw; model_s = ns;
        end
        ch_w = 0; ch_s = 0; first_w = -1;
        prev_w = code_w; prev_s = code_s;
        up = 1'b1;
        for (int i = 1; i <= 76; i++) begin
            cycles(1);
            if (i == 60) up = 1'b0;
            if (code_w !== prev_w) begin
                ch_w++;
                if (first_w < 0) first_w = i;
                prev_w = code_w;
            end
            if (code_s !== prev_s) begin
                ch_s++;
                prev_s = code_s;
            end
        end
        n_checks++;
        if (first_w != 8) $display("FAIL hold_latency: got edge %0d expected edge %0d", first_w, 8);
        else n_pass++;
        n_checks++;
        if (ch_w != exp_ch_w || ch_s != exp_ch_s)
            $display("FAIL hold_steps: got %0d/%0d expected %0d/%0d", ch_w, ch_s, exp_ch_w, exp_ch_s);
        else n_pass++;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL hold_final: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] mask;
        int unsigned r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: mask = 3'b001;
                3, 4, 5: mask = 3'b010;
                6:       mask = 3'b011;
                7:       mask = 3'b100 | 3'($urandom_range(0, 3));
                default: mask = 3'b000;
            endcase
            if (mask == 3'b000) pulse_clear();
            else press(mask, int'($urandom_range(DB, DB + 5)));
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_async();
        if (model_locked) pulse_clear();
        press(3'b001, 5); press(3'b001, 5);
        up = 1'b1;
        cycles(5);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL reset_async: got %h expected %h", obs, exp_vec());
        else n_pass++;
        up = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(12);
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset_state();
        test_debounce();
        test_wrap_saturate();
        test_lock();
        test_simultaneous();
        test_autorepeat();
        test_random();
        test_reset_async();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
